// File: rtl/soft_processor_pio_out.sv
// Avalon-MM 8-bit parallel output port with a timed pulse generator.
// A pulse write inverts the masked bits for max(len_reg,1) cycles.
module soft_processor_pio_out (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        pulse_done
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_LEN   = 3'd1;
    localparam logic [2:0] A_PULSE = 3'd2;
    localparam logic [2:0] A_SET   = 3'd4;
    localparam logic [2:0] A_CLR   = 3'd5;

    state_t      state;
    logic [7:0]  data_reg;
    logic [15:0] len_reg;
    logic [7:0]  pulse_mask;
    logic [15:0] cnt;
    logic        done_flag;
    logic        busy;
    logic        wr;
    logic [7:0]  wbyte;
    logic [15:0] eff_len;
    logic        start;
    logic        unused_hi;

    assign wr        = chipselect & ~write_n;
    assign wbyte     = writedata[7:0];
    assign busy      = (state == ACTIVE);
    assign eff_len   = (len_reg == 16'd0) ? 16'd1 : len_reg;
    assign unused_hi = ^writedata[31:16];

    // A pulse is accepted only from IDLE with a non-zero mask.
    assign start = wr && (address == A_PULSE) && (state == IDLE)
                   && (wbyte != 8'd0);

    assign out_port = data_reg ^ (pulse_mask & {8{busy}});

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= 8'd0;
            len_reg  <= 16'd1;
        end else if (wr) begin
            case (address)
                A_DATA:  data_reg <= wbyte;
                A_LEN:   len_reg  <= writedata[15:0];
                A_SET:   data_reg <= data_reg | wbyte;
                A_CLR:   data_reg <= data_reg & ~wbyte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pulse_mask <= 8'd0;
            cnt        <= 16'd0;
            done_flag  <= 1'b0;
            pulse_done <= 1'b0;
        end else begin
            pulse_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACTIVE;
                        pulse_mask <= wbyte;
                        cnt        <= eff_len - 16'd1;
                        done_flag  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        state      <= IDLE;
                        pulse_done <= 1'b1;
                        done_flag  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads ignore chipselect so readdata always trails address by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                A_DATA:  readdata <= {24'd0, data_reg};
                A_LEN:   readdata <= {16'd0, len_reg};
                A_PULSE: readdata <= {30'd0, done_flag, busy};
                default: readdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_soft_processor_pio_out.sv
// Directed self-checking bench for soft_processor_pio_out.
// Each vector drives the bus for one cycle, then checks outputs.
module tb_soft_processor_pio_out;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_done;

    int tests;
    int fails;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_out;
        logic        exp_done;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    soft_processor_pio_out dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_done (pulse_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wv(input logic [2:0] a, input logic [31:0] d,
                      input logic [7:0] o, input logic dn);
        vec_t v;
        v = '{1'b1, a, d, o, dn, 1'b0, 32'd0};
        vq.push_back(v);
    endtask

    task automatic rv(input logic [2:0] a, input logic [7:0] o,
                      input logic dn, input logic c, input logic [31:0] r);
        vec_t v;
        v = '{1'b0, a, 32'd0, o, dn, c, r};
        vq.push_back(v);
    endtask

    task automatic drive(input logic w, input logic [2:0] a,
                         input logic [31:0] d);
        chipselect = w;
        write_n    = ~w;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle_bus();
        drive(1'b0, 3'd3, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_bus();
        // Bus activity during reset must be ignored.
        drive(1'b1, 3'd0, 32'hFF);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {24'd0, out_port}, 32'd0);
        check("rst_rd", readdata, 32'd0);
        check("rst_done", {31'd0, pulse_done}, 32'd0);
        reset = 1'b0;
        idle_bus();

        rv(3'd1, 8'h00, 1'b0, 1'b1, 32'd1);
        rv(3'd0, 8'h00, 1'b0, 1'b1, 32'd0);
        wv(3'd0, 32'hDEADBEA5, 8'hA5, 1'b0);
        rv(3'd0, 8'hA5, 1'b0, 1'b1, 32'h000000A5);
        wv(3'd0, 32'h000000F0, 8'hF0, 1'b0);
        wv(3'd4, 32'h0000000F, 8'hFF, 1'b0);
        wv(3'd5, 32'h00000081, 8'h7E, 1'b0);
        rv(3'd4, 8'h7E, 1'b0, 1'b1, 32'd0);
        rv(3'd5, 8'h7E, 1'b0, 1'b1, 32'd0);
        wv(3'd3, 32'h000000FF, 8'h7E, 1'b0);
        wv(3'd6, 32'h000000FF, 8'h7E, 1'b0);
        wv(3'd7, 32'h000000FF, 8'h7E, 1'b0);
        rv(3'd3, 8'h7E, 1'b0, 1'b1, 32'd0);
        rv(3'd6, 8'h7E, 1'b0, 1'b1, 32'd0);
        rv(3'd7, 8'h7E, 1'b0, 1'b1, 32'd0);
        rv(3'd0, 8'h7E, 1'b0, 1'b1, 32'h0000007E);
        // Three-cycle pulse on bit 0.
        wv(3'd1, 32'hFFFF0003, 8'h7E, 1'b0);
        rv(3'd1, 8'h7E, 1'b0, 1'b1, 32'd3);
        wv(3'd0, 32'h00000000, 8'h00, 1'b0);
        rv(3'd2, 8'h00, 1'b0, 1'b1, 32'd0);
        wv(3'd2, 32'h00000001, 8'h01, 1'b0);
        rv(3'd3, 8'h01, 1'b0, 1'b0, 32'd0);
        rv(3'd2, 8'h01, 1'b0, 1'b1, 32'd1);
        rv(3'd3, 8'h00, 1'b1, 1'b0, 32'd0);
        rv(3'd2, 8'h00, 1'b0, 1'b1, 32'd2);
        // Zero-mask pulse write is ignored; done_flag stays set.
        wv(3'd2, 32'h00000000, 8'h00, 1'b0);
        rv(3'd2, 8'h00, 1'b0, 1'b1, 32'd2);
        rv(3'd2, 8'h00, 1'b0, 1'b1, 32'd2);
        // Length 0 behaves as 1.
        wv(3'd1, 32'h00000000, 8'h00, 1'b0);
        wv(3'd2, 32'h00000080, 8'h80, 1'b0);
        rv(3'd2, 8'h00, 1'b1, 1'b1, 32'd1);
        rv(3'd2, 8'h00, 1'b0, 1'b1, 32'd2);
        // Ten-cycle pulse with writes while active.
        wv(3'd1, 32'h0000000A, 8'h00, 1'b0);
        wv(3'd2, 32'h00000001, 8'h01, 1'b0);
        wv(3'd2, 32'h00000002, 8'h01, 1'b0);
        wv(3'd0, 32'h00000010, 8'h11, 1'b0);
        wv(3'd1, 32'h00000002, 8'h11, 1'b0);
        wv(3'd4, 32'h00000004, 8'h15, 1'b0);
        wv(3'd5, 32'h00000004, 8'h11, 1'b0);
        rv(3'd2, 8'h11, 1'b0, 1'b1, 32'd1);
        rv(3'd3, 8'h11, 1'b0, 1'b0, 32'd0);
        rv(3'd3, 8'h11, 1'b0, 1'b0, 32'd0);
        rv(3'd3, 8'h11, 1'b0, 1'b0, 32'd0);
        rv(3'd3, 8'h10, 1'b1, 1'b0, 32'd0);
        rv(3'd1, 8'h10, 1'b0, 1'b1, 32'd2);
        // New length 2 applies to the next pulse.
        wv(3'd2, 32'h00000040, 8'h50, 1'b0);
        rv(3'd3, 8'h50, 1'b0, 1'b0, 32'd0);
        rv(3'd3, 8'h10, 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wr, vq[i].addr, vq[i].data);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out", i), {24'd0, out_port},
                  {24'd0, vq[i].exp_out});
            check($sformatf("v%0d_done", i), {31'd0, pulse_done},
                  {31'd0, vq[i].exp_done});
            if (vq[i].chk_rd)
                check($sformatf("v%0d_rd", i), readdata, vq[i].exp_rd);
        end

        // Reset in the middle of a ten-cycle pulse aborts it silently.
        drive(1'b1, 3'd0, 32'h00000003);
        @(posedge clk);
        #1;
        drive(1'b1, 3'd1, 32'h0000000A);
        @(posedge clk);
        #1;
        drive(1'b1, 3'd2, 32'h00000004);
        @(posedge clk);
        #1;
        check("ab_start", {24'd0, out_port}, 32'h7);
        idle_bus();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("ab_hold", {24'd0, out_port}, 32'h7);
        end
        reset = 1'b1;
        drive(1'b1, 3'd0, 32'h000000AA);
        @(posedge clk);
        #1;
        check("ab_out", {24'd0, out_port}, 32'd0);
        check("ab_done", {31'd0, pulse_done}, 32'd0);
        check("ab_rd", readdata, 32'd0);
        reset = 1'b0;
        drive(1'b0, 3'd2, 32'd0);
        @(posedge clk);
        #1;
        check("ab_status", readdata, 32'd0);
        drive(1'b0, 3'd1, 32'd0);
        @(posedge clk);
        #1;
        check("ab_len", readdata, 32'd1);
        idle_bus();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("ab_nodone", {31'd0, pulse_done}, 32'd0);
            check("ab_quiet", {24'd0, out_port}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/soft_processor_pio_out.md
SOFT_PROCESSOR_PIO_OUT -- requirements
Module: soft_processor_pio_out

Interface
REQ-001 The block SHALL be one clock domain with a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state SHALL change only on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 address  in  3  Avalon-MM word offset.
REQ-005 chipselect  in  1  slave select; writes SHALL be qualified by it.
REQ-006 write_n  in  1  active-low write strobe; write = chipselect & ~write_n.
REQ-007 writedata  in  32  write data; only bits [15:0] SHALL be used, and only where stated.
REQ-008 readdata  out  32  registered read data.
REQ-009 out_port  out  8  driven output = data_reg XOR (pulse_mask AND busy).
REQ-010 pulse_done  out  1  one-cycle strobe at the end of each timed pulse.

Function
REQ-011 Register map: 0 DATA (R/W, 8b), 1 PULSE_LEN (R/W, 16b), 2 PULSE/STATUS (W: mask; R: status), 4 OUTSET (W), 5 OUTCLEAR (W); offsets 3, 6 and 7 SHALL ignore writes and read 0.
REQ-012 Write DATA: data_reg <= writedata[7:0] at the write edge; new value visible on out_port immediately after that edge.
REQ-013 Write OUTSET: data_reg <= data_reg | writedata[7:0]; OUTSET reads 0.
REQ-014 Write OUTCLEAR: data_reg <= data_reg & ~writedata[7:0]; OUTCLEAR reads 0.
REQ-015 Write PULSE_LEN: len_reg <= writedata[15:0]; a value of 0 SHALL be treated as 1.
REQ-016 FSM states IDLE and ACTIVE; busy = (state == ACTIVE).
REQ-017 IDLE -> ACTIVE on a PULSE write with writedata[7:0] != 0:
- pulse_mask <= writedata[7:0]
- cnt <= max(len_reg,1) - 1
- done_flag <= 0
REQ-018 A PULSE write with a zero mask SHALL be ignored.
REQ-019 A PULSE write while ACTIVE SHALL be ignored; mask and count are unchanged.
REQ-020 ACTIVE, cnt != 0: cnt <= cnt - 1 each cycle.
REQ-021 ACTIVE, cnt == 0: next state IDLE, pulse_done = 1 for exactly that following cycle, done_flag <= 1.
REQ-022 Pulse width: the masked bits SHALL be inverted on out_port for exactly max(len_reg,1) cycles, starting the cycle after the PULSE write edge.
REQ-023 A PULSE_LEN write while ACTIVE SHALL affect only later pulses.
REQ-024 DATA, OUTSET and OUTCLEAR writes while ACTIVE SHALL update data_reg; out_port = new data_reg XOR mask until the pulse ends.
REQ-025 Read latency: readdata SHALL be registered every cycle from address, independent of chipselect, giving a 1-cycle latency.
- DATA reads {24'b0, data_reg}.
- PULSE_LEN reads {16'b0, len_reg}.
- STATUS reads {30'b0, done_flag, busy}.
REQ-026 done_flag is sticky; it SHALL clear only on an accepted pulse start or on reset.

Reset
REQ-027 While reset = 1 at a clock edge, the block SHALL reset regardless of bus activity.
- data_reg = 0, len_reg = 1, pulse_mask = 0, cnt = 0
- state = IDLE, done_flag = 0
- readdata = 0, out_port = 0, pulse_done = 0
REQ-028 Reset asserted during ACTIVE SHALL abort the pulse without asserting pulse_done.

Verification
REQ-029 Reset then write DATA = 0xA5 -> out_port = 0xA5 from the next cycle; read offset 0 -> readdata = 0x000000A5 one cycle after the address is presented.
REQ-030 DATA = 0xF0, write OUTSET = 0x0F, then OUTCLEAR = 0x81 -> out_port shows 0xFF, then 0x7E.
REQ-031 PULSE_LEN = 3, DATA = 0x00, write PULSE = 0x01 -> out_port = 0x01 for exactly 3 cycles, then 0x00; pulse_done high for 1 cycle on the first cycle back at 0x00; STATUS reads 0x2.
REQ-032 PULSE_LEN = 0, write PULSE = 0x80 -> out_port bit7 high for exactly 1 cycle.
REQ-033 PULSE_LEN = 10, write PULSE = 0x01; on cycle 2 write PULSE = 0x02 and DATA = 0x10 -> second PULSE write ignored; out_port = 0x11 until cycle 10, then 0x10.
REQ-034 Assert reset at cycle 4 of a 10-cycle pulse -> out_port = 0 and STATUS = 0 after the reset edge; pulse_done never asserts.
